// File: rtl/reg_hex_overlay_if.sv
// Character-ROM port of the register hex overlay: the overlay issues the
// address and the ROM returns one glyph row a clock later.
interface reg_hex_overlay_if;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/reg_hex_overlay.sv
// VGA text overlay that shows a bank of registers as "Rn=hex" rows, with
// per-frame snapshots, a freeze control and timed change highlighting.
module reg_hex_overlay #(
    parameter int          NUM_REGS    = 8,
    parameter int          REG_WIDTH   = 8,
    parameter int          ORIGIN_X    = 192,
    parameter int          ORIGIN_Y    = 208,
    parameter logic [11:0] FG_RGB      = 12'h00F,
    parameter logic [11:0] HL_RGB      = 12'hF00,
    parameter logic [11:0] BG_RGB      = 12'hFFF,
    parameter int          HOLD_FRAMES = 60
) (
    input  logic                          clkvga,
    input  logic                          rst,
    input  logic                          video_on,
    input  logic [9:0]                    x,
    input  logic [9:0]                    y,
    input  logic [NUM_REGS*REG_WIDTH-1:0] reg_flat,
    input  logic                          freeze,
    reg_hex_overlay_if.master             rom_if,
    output logic [11:0]                   rgb
);
    localparam int          HEX_DIGITS = (REG_WIDTH + 3) / 4;
    localparam int          NUM_COLS   = 3 + HEX_DIGITS;
    localparam int          PAD_W      = 4 * HEX_DIGITS;
    localparam logic [10:0] BLK_W      = 11'(8 * NUM_COLS);
    localparam logic [10:0] BLK_H      = 11'(16 * NUM_REGS);

    function automatic logic [6:0] hex_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (7'h30 + {3'b000, d}) : (7'h37 + {3'b000, d});
    endfunction

    logic [REG_WIDTH-1:0] r_snap   [NUM_REGS];
    logic [7:0]           r_hl_cnt [NUM_REGS];
    logic                 r_origin_d;
    logic                 r_frame_start;
    logic [2:0]           r_px0, r_px1;
    logic                 r_in0, r_in1;
    logic                 r_hl0, r_hl1;
    logic                 r_von0, r_von1;

    logic [10:0]          w_dx, w_dy;
    logic [7:0]           w_col;
    logic [6:0]           w_row;
    logic [3:0]           w_grow;
    logic                 w_in_block;
    logic                 w_origin;
    logic [PAD_W-1:0]     w_sel;
    logic                 w_hl_nz;
    logic [3:0]           w_digit;
    logic [6:0]           w_ascii;
    logic                 w_hl;

    // Coordinates left of / above the origin wrap to large values and fall out of the block.
    assign w_dx       = {1'b0, x} - 11'(ORIGIN_X);
    assign w_dy       = {1'b0, y} - 11'(ORIGIN_Y);
    assign w_col      = w_dx[10:3];
    assign w_row      = w_dy[10:4];
    assign w_grow     = w_dy[3:0];
    assign w_in_block = (w_dx < BLK_W) && (w_dy < BLK_H);
    assign w_origin   = (x == 10'd0) && (y == 10'd0);

    always_comb begin
        w_sel   = '0;
        w_hl_nz = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_row == 7'(i)) begin
                w_sel   = PAD_W'(r_snap[i]);
                w_hl_nz = (r_hl_cnt[i] != 8'd0);
            end
        end
    end

    always_comb begin
        w_digit = 4'h0;
        for (int k = 0; k < HEX_DIGITS; k++) begin
            if (w_col == 8'(3 + k)) begin
                w_digit = w_sel[4*(HEX_DIGITS-1-k) +: 4];
            end
        end
    end

    always_comb begin
        w_ascii = 7'h00;
        if (w_in_block) begin
            case (w_col)
                8'd0:    w_ascii = 7'h52;
                8'd1:    w_ascii = hex_ascii(w_row[3:0]);
                8'd2:    w_ascii = 7'h3D;
                default: w_ascii = hex_ascii(w_digit);
            endcase
        end
    end

    // Label columns never take the highlight colour.
    assign w_hl = w_in_block && (w_col >= 8'd3) && w_hl_nz;

    always_ff @(posedge clkvga or negedge rst) begin
        if (!rst) begin
            rom_if.rom_addr <= 11'd0;
            r_px0  <= 3'd0;
            r_px1  <= 3'd0;
            r_in0  <= 1'b0;
            r_in1  <= 1'b0;
            r_hl0  <= 1'b0;
            r_hl1  <= 1'b0;
            r_von0 <= 1'b0;
            r_von1 <= 1'b0;
            rgb    <= 12'h000;
        end else begin
            rom_if.rom_addr <= {w_ascii, w_grow};
            r_px0  <= w_dx[2:0];
            r_in0  <= w_in_block;
            r_hl0  <= w_hl;
            r_von0 <= video_on;
            r_px1  <= r_px0;
            r_in1  <= r_in0;
            r_hl1  <= r_hl0;
            r_von1 <= r_von0;
            if (!r_von1) begin
                rgb <= 12'h000;
            end else if (!r_in1) begin
                rgb <= BG_RGB;
            end else if (rom_if.rom_data[3'd7 - r_px1]) begin
                rgb <= r_hl1 ? HL_RGB : FG_RGB;
            end else begin
                rgb <= BG_RGB;
            end
        end
    end

    // Snapshots change only on the clock after the (0,0) pulse, which is outside the block.
    always_ff @(posedge clkvga or negedge rst) begin
        if (!rst) begin
            r_origin_d    <= 1'b0;
            r_frame_start <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_snap[i]   <= '0;
                r_hl_cnt[i] <= 8'd0;
            end
        end else begin
            r_origin_d    <= w_origin;
            r_frame_start <= w_origin && !r_origin_d;
            if (r_frame_start) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (!freeze && (reg_flat[i*REG_WIDTH +: REG_WIDTH] != r_snap[i])) begin
                        r_snap[i]   <= reg_flat[i*REG_WIDTH +: REG_WIDTH];
                        r_hl_cnt[i] <= 8'(HOLD_FRAMES);
                    end else if (r_hl_cnt[i] != 8'd0) begin
                        r_hl_cnt[i] <= r_hl_cnt[i] - 8'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_hex_overlay.sv
// Bench for reg_hex_overlay: two instances (8x8-bit and 16x12-bit) sharing the
// raster inputs, each with its own character ROM.
module tb_reg_hex_overlay;
    localparam int          OX = 192;
    localparam int          OY = 208;
    localparam logic [11:0] FG = 12'h00F;
    localparam logic [11:0] HL = 12'hF00;
    localparam logic [11:0] BG = 12'hFFF;

    typedef struct {
        logic [11:0] ea;
        logic [11:0] eb;
    } exp_t;

    typedef struct {
        bit         b;
        int         row;
        int         col;
        int         gr;
        logic [6:0] asc;
    } vec_t;

    logic         clkvga = 1'b0;
    logic         rst;
    logic         video_on;
    logic         freeze;
    logic [9:0]   x, y;
    logic [63:0]  rf_a;
    logic [191:0] rf_b;
    logic [11:0]  rgb_a, rgb_b;

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_hl_seen;
    bit   in_rst;
    int   val    [2][16];
    int   m_snap [2][16];
    int   m_hl   [2][16];
    logic [10:0] ra_a, ra_b;
    exp_t q [$];
    vec_t tv [$];

    reg_hex_overlay_if if_a ();
    reg_hex_overlay_if if_b ();

    reg_hex_overlay #(.NUM_REGS(8), .REG_WIDTH(8), .HOLD_FRAMES(3)) dut_a (
        .clkvga(clkvga), .rst(rst), .video_on(video_on), .x(x), .y(y),
        .reg_flat(rf_a), .freeze(freeze), .rom_if(if_a), .rgb(rgb_a));

    reg_hex_overlay #(.NUM_REGS(16), .REG_WIDTH(12), .HOLD_FRAMES(5)) dut_b (
        .clkvga(clkvga), .rst(rst), .video_on(video_on), .x(x), .y(y),
        .reg_flat(rf_b), .freeze(freeze), .rom_if(if_b), .rgb(rgb_b));

    always #5 clkvga = ~clkvga;

    function automatic logic [7:0] glyph(input logic [10:0] a);
        logic [31:0] h;
        h = {21'd0, a} * 32'd40503;
        return h[14:7];
    endfunction

    always @(posedge clkvga) begin
        if_a.rom_data <= glyph(if_a.rom_addr);
        if_b.rom_data <= glyph(if_b.rom_addr);
    end

    always_comb begin
        rf_a = '0;
        rf_b = '0;
        for (int i = 0; i < 8; i++)  rf_a[i*8 +: 8]   = 8'(val[0][i]);
        for (int i = 0; i < 16; i++) rf_b[i*12 +: 12] = 12'(val[1][i]);
    end

    function automatic int nrows(input bit b); return b ? 16 : 8; endfunction
    function automatic int ndig(input bit b);  return b ? 3 : 2;  endfunction
    function automatic int hold(input bit b);  return b ? 5 : 3;  endfunction
    function automatic int hexc(input int d);  return (d < 10) ? 48 + d : 65 + d - 10; endfunction

    function automatic int exp_char(input bit b, input int row, input int col);
        int k;
        if (col == 0) return 'h52;
        if (col == 1) return hexc(row);
        if (col == 2) return 'h3D;
        k = col - 3;
        return hexc((m_snap[b][row] >> (4 * (ndig(b) - 1 - k))) & 15);
    endfunction

    function automatic logic [11:0] exp_rgb(input bit b, input int px, input int py, input bit von);
        int row, col, gr, ch;
        logic [7:0] g;
        if (!von) return 12'h000;
        if (px < OX || px >= OX + 8 * (3 + ndig(b)) || py < OY || py >= OY + 16 * nrows(b))
            return BG;
        row = (py - OY) / 16;
        col = (px - OX) / 8;
        gr  = (py - OY) % 16;
        ch  = exp_char(b, row, col);
        g   = glyph(11'(ch * 16 + gr));
        if (!g[3'(7 - (px % 8))]) return BG;
        if (col >= 3 && m_hl[b][row] != 0) return HL;
        return FG;
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16; i++) begin
                m_snap[b][i] = 0;
                m_hl[b][i]   = 0;
            end
    endfunction

    function automatic void model_frame();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < nrows(1'(b)); i++) begin
                if (!freeze && val[b][i] != m_snap[b][i]) begin
                    m_snap[b][i] = val[b][i];
                    m_hl[b][i]   = hold(1'(b));
                end else if (m_hl[b][i] > 0) begin
                    m_hl[b][i] = m_hl[b][i] - 1;
                end
            end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One pixel per clock: check the pixel driven three negedges ago, then drive the next.
    task automatic cycle(input int px, input int py, input bit von);
        exp_t e;
        @(negedge clkvga);
        ra_a = if_a.rom_addr;
        ra_b = if_b.rom_addr;
        if (q.size() >= 3) begin
            e = q.pop_front();
            chk("rgb_a", 32'(rgb_a), 32'(e.ea));
            chk("rgb_b", 32'(rgb_b), 32'(e.eb));
            if (rgb_a == HL) n_hl_seen++;
        end
        x        = 10'(px);
        y        = 10'(py);
        video_on = von;
        e.ea = in_rst ? 12'h000 : exp_rgb(1'b0, px, py, von);
        e.eb = in_rst ? 12'h000 : exp_rgb(1'b1, px, py, von);
        q.push_back(e);
    endtask

    task automatic frame(input int held);
        for (int k = 0; k < held; k++) cycle(0, 0, 1'b0);
        cycle(1, 0, 1'b0);
        cycle(2, 0, 1'b0);
        model_frame();
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1, input bit von);
        for (int yy = y0; yy < y1; yy++)
            for (int xx = x0; xx < x1; xx++)
                cycle(xx, yy, von);
    endtask

    task automatic flush();
        repeat (3) cycle(700, 5, 1'b0);
    endtask

    task automatic probe(input string name, input bit b, input int row, input int col,
                         input int gr, input logic [6:0] asc);
        cycle(OX + 8 * col, OY + 16 * row + gr, 1'b1);
        cycle(700, 5, 1'b1);
        chk(name, 32'(b ? ra_b : ra_a), 32'({asc, 4'(gr)}));
    endtask

    task automatic do_release();
        repeat (3) cycle(700, 5, 1'b1);
        @(posedge clkvga);
        #1;
        rst    = 1'b1;
        in_rst = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; in_rst = 1'b1; video_on = 1'b0; freeze = 1'b0;
        x = 10'd700; y = 10'd5;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16; i++) val[b][i] = 0;
        model_reset();

        tv.push_back('{1'b0, 0, 0, 0, 7'h52});
        tv.push_back('{1'b0, 0, 1, 3, 7'h30});
        tv.push_back('{1'b0, 0, 2, 5, 7'h3D});
        tv.push_back('{1'b0, 0, 3, 7, 7'h33});
        tv.push_back('{1'b0, 0, 4, 15, 7'h46});
        tv.push_back('{1'b0, 7, 0, 2, 7'h52});
        tv.push_back('{1'b0, 7, 1, 4, 7'h37});
        tv.push_back('{1'b0, 7, 2, 6, 7'h3D});
        tv.push_back('{1'b0, 7, 3, 8, 7'h41});
        tv.push_back('{1'b0, 7, 4, 9, 7'h35});
        tv.push_back('{1'b0, 0, 5, 1, 7'h00});
        tv.push_back('{1'b0, 8, 0, 3, 7'h00});
        tv.push_back('{1'b1, 15, 0, 0, 7'h52});
        tv.push_back('{1'b1, 15, 1, 1, 7'h46});
        tv.push_back('{1'b1, 15, 3, 2, 7'h30});
        tv.push_back('{1'b1, 15, 4, 3, 7'h41});
        tv.push_back('{1'b1, 15, 5, 4, 7'h42});
        tv.push_back('{1'b1, 15, 6, 5, 7'h00});
        tv.push_back('{1'b1, 16, 0, 6, 7'h00});
        tv.push_back('{1'b1, 10, 1, 7, 7'h41});
        tv.push_back('{1'b1, 10, 3, 8, 7'h46});
        tv.push_back('{1'b1, 10, 5, 9, 7'h43});

        repeat (2) @(posedge clkvga);
        #1;
        chk("reset_rgb_a", 32'(rgb_a), 32'h0);
        chk("reset_rgb_b", 32'(rgb_b), 32'h0);
        chk("reset_addr_a", 32'(if_a.rom_addr), 32'h0);
        chk("reset_addr_b", 32'(if_b.rom_addr), 32'h0);
        do_release();

        // Content of rows via the ROM address, then full pixel rows.
        val[0][0] = 'h3F; val[0][7] = 'hA5; val[1][15] = 'h0AB; val[1][10] = 'hF3C;
        frame(1);
        foreach (tv[i]) probe($sformatf("addr_v%0d", i), tv[i].b, tv[i].row, tv[i].col, tv[i].gr, tv[i].asc);
        scan(OX - 8, OX + 48, OY, OY + 16, 1'b1);
        scan(OX - 8, OX + 56, OY + 112, OY + 128, 1'b1);
        flush();

        // Highlight lifetime of a single change.
        val[0][2] = 'h10;
        for (int f = 1; f <= 5; f++) begin
            frame(1);
            n_hl_seen = 0;
            scan(OX + 24, OX + 40, OY + 32, OY + 48, 1'b1);
            flush();
            chk($sformatf("r2_hl_frame%0d", f), 32'(n_hl_seen > 0), 32'(f <= 3));
            n_hl_seen = 0;
            scan(OX + 24, OX + 40, OY + 16, OY + 32, 1'b1);
            flush();
            chk($sformatf("r1_no_hl_frame%0d", f), 32'(n_hl_seen > 0), 32'h0);
        end

        // Freeze holds the display; the update and highlight follow the release.
        val[0][1] = 'h21;
        repeat (4) frame(1);
        freeze = 1'b1;
        val[0][1] = 'hFF;
        frame(1);
        frame(2);
        probe("frozen_digit", 1'b0, 1, 3, 0, 7'h32);
        n_hl_seen = 0;
        scan(OX + 24, OX + 40, OY + 16, OY + 32, 1'b1);
        flush();
        chk("frozen_no_hl", 32'(n_hl_seen > 0), 32'h0);
        freeze = 1'b0;
        probe("unfrozen_before_frame", 1'b0, 1, 4, 1, 7'h31);
        frame(1);
        probe("unfrozen_digit_hi", 1'b0, 1, 3, 2, 7'h46);
        probe("unfrozen_digit_lo", 1'b0, 1, 4, 3, 7'h46);
        n_hl_seen = 0;
        scan(OX + 24, OX + 40, OY + 16, OY + 32, 1'b1);
        flush();
        chk("unfrozen_hl", 32'(n_hl_seen > 0), 32'h1);

        // Blanking inside the block.
        scan(OX, OX + 40, OY, OY + 8, 1'b0);
        scan(OX, OX + 40, OY + 8, OY + 12, 1'b1);
        flush();

        // Asynchronous reset while R3 is highlighted.
        val[0][3] = 'h77;
        frame(1);
        n_hl_seen = 0;
        scan(OX + 24, OX + 40, OY + 48, OY + 64, 1'b1);
        flush();
        chk("r3_hl_before_reset", 32'(n_hl_seen > 0), 32'h1);
        scan(OX + 24, OX + 40, OY + 48, OY + 52, 1'b1);
        @(posedge clkvga);
        #2;
        rst    = 1'b0;
        in_rst = 1'b1;
        #1;
        chk("async_rst_rgb_a", 32'(rgb_a), 32'h0);
        chk("async_rst_rgb_b", 32'(rgb_b), 32'h0);
        chk("async_rst_addr_a", 32'(if_a.rom_addr), 32'h0);
        q.delete();
        model_reset();
        do_release();
        n_hl_seen = 0;
        scan(OX + 24, OX + 40, OY + 48, OY + 64, 1'b1);
        flush();
        chk("r3_no_hl_after_reset", 32'(n_hl_seen > 0), 32'h0);
        probe("r3_zero_after_reset", 1'b0, 3, 3, 0, 7'h30);
        frame(1);
        probe("r3_value_after_frame", 1'b0, 3, 4, 0, 7'h37);

        // Randomized frames against the model.
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 16; i++) begin
                if (i < 8 && $urandom_range(0, 3) == 0) val[0][i] = int'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) val[1][i] = int'($urandom_range(0, 4095));
            end
            freeze = ($urandom_range(0, 3) == 0);
            frame(int'($urandom_range(1, 3)));
            repeat (100)
                cycle(int'($urandom_range(OX - 16, OX + 64)),
                      int'($urandom_range(OY - 16, OY + 280)),
                      $urandom_range(0, 9) != 0);
        end
        freeze = 1'b0;
        flush();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
